// File: rtl/game_pkg.sv
// Shared types and defaults for the switch-matching game controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PLAY   = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam int GAME_SECONDS_DEF = 30;
    localparam int MATCH_HOLD_DEF   = 16;
    localparam int SCORE_W          = 4;
    localparam int TIME_W           = 6;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/match_filter.sv
// Counts consecutive cycles of sw==target; hit flags the HOLD-th equal cycle.
module match_filter
    import game_pkg::*;
#(
    parameter int HOLD = MATCH_HOLD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic equal,
    output logic hit
);

    localparam logic [7:0] LAST = 8'(HOLD - 1);

    logic [7:0] cnt;

    assign hit = !clear && equal && (cnt == LAST);

    // Restarting on hit keeps the count bounded by HOLD-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || !equal || hit)
            cnt <= '0;
        else
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/game_controller.sv
// Round controller: timed game where holding sw on target for MATCH_HOLD cycles scores a point.
module game_controller
    import game_pkg::*;
#(
    parameter int GAME_SECONDS = GAME_SECONDS_DEF,
    parameter int MATCH_HOLD   = MATCH_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               tick,
    input  logic [7:0]         sw,
    input  logic [7:0]         target,
    output logic               new_number,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  time_remaining,
    output logic               playing,
    output logic               game_end
);

    localparam logic [TIME_W-1:0] T_LOAD = TIME_W'(GAME_SECONDS);

    state_t              state, state_nxt;
    logic [SCORE_W-1:0]  score_nxt;
    logic [TIME_W-1:0]   time_nxt;
    logic                nn_nxt, playing_nxt, end_nxt;
    logic                hit, clear, running, idle_like, time_out;

    assign running   = (state == ST_SETTLE) || (state == ST_PLAY);
    assign idle_like = (state == ST_IDLE) || (state == ST_OVER);
    assign clear     = (state != ST_PLAY);
    assign time_out  = running && tick && (time_remaining == TIME_W'(1));

    match_filter #(.HOLD(MATCH_HOLD)) u_match (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .equal (sw == target),
        .hit   (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            score          <= '0;
            time_remaining <= T_LOAD;
            new_number     <= 1'b0;
            playing        <= 1'b0;
            game_end       <= 1'b0;
        end else begin
            state          <= state_nxt;
            score          <= score_nxt;
            time_remaining <= time_nxt;
            new_number     <= nn_nxt;
            playing        <= playing_nxt;
            game_end       <= end_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_OVER: if (start) state_nxt = ST_SETTLE;
            ST_SETTLE:        state_nxt = time_out ? ST_OVER : ST_PLAY;
            ST_PLAY: begin
                if (time_out)
                    state_nxt = ST_OVER;
                else if (hit)
                    state_nxt = ST_SETTLE;
            end
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Running out of time wins over a match completing in the same cycle.
    always_comb begin
        score_nxt = score;
        time_nxt  = time_remaining;
        nn_nxt    = 1'b0;
        if (idle_like && start) begin
            score_nxt = '0;
            time_nxt  = T_LOAD;
            nn_nxt    = 1'b1;
        end
        if (running && tick && (time_remaining != '0))
            time_nxt = time_remaining - TIME_W'(1);
        if ((state == ST_PLAY) && hit && !time_out) begin
            score_nxt = sat_inc(score);
            nn_nxt    = 1'b1;
        end
        playing_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_PLAY);
        end_nxt     = (state_nxt == ST_OVER);
    end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: vector table, directed corner sequences and a random run vs a round-level model.
module tb_game_controller;
    import game_pkg::*;

    localparam int GS = 30;
    localparam int MH = 4;
    localparam int P_IDLE = 0, P_SETTLE = 1, P_PLAY = 2, P_OVER = 3;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, tick = 1'b0;
    logic [7:0] sw = 8'h00, target = 8'h3c;
    logic       new_number, playing, game_end;
    logic [3:0] score;
    logic [5:0] time_remaining;

    game_controller #(.GAME_SECONDS(GS), .MATCH_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .sw(sw), .target(target),
        .new_number(new_number), .score(score), .time_remaining(time_remaining),
        .playing(playing), .game_end(game_end)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_phase, m_score, m_time, m_run;
    bit m_nn, req_pending;

    typedef struct {
        bit st, tk, eq;
        int nn, score, tim, pl, en;
    } vec_t;
    vec_t vt[14];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_score = 0; m_time = GS; m_run = 0; m_nn = 0;
        req_pending = 0;
    endtask

    // Round-level rules: run length of equal cycles, seconds left, score capped at 15.
    task automatic model_step(bit st, bit tk, bit eq);
        bit matched, ended;
        m_nn = 0;
        ended = 0;
        case (m_phase)
            P_IDLE, P_OVER: if (st) begin
                m_score = 0; m_time = GS; m_nn = 1; m_phase = P_SETTLE;
            end
            P_SETTLE: begin
                m_run = 0;
                if (tk && m_time > 0) begin m_time--; ended = (m_time == 0); end
                m_phase = ended ? P_OVER : P_PLAY;
            end
            default: begin
                m_run   = eq ? m_run + 1 : 0;
                matched = (m_run == MH);
                if (tk && m_time > 0) begin m_time--; ended = (m_time == 0); end
                if (ended) m_phase = P_OVER;
                else if (matched) begin
                    m_score = (m_score < 15) ? m_score + 1 : 15;
                    m_nn = 1; m_phase = P_SETTLE; m_run = 0;
                end
            end
        endcase
    endtask

    task automatic check_model(string tag);
        check({tag, ".new_number"}, new_number, m_nn);
        check({tag, ".score"}, score, m_score);
        check({tag, ".time"}, time_remaining, m_time);
        check({tag, ".playing"}, playing, (m_phase == P_SETTLE || m_phase == P_PLAY));
        check({tag, ".game_end"}, game_end, (m_phase == P_OVER));
    endtask

    // Random generator answers a new_number request one cycle later.
    task automatic drive(bit st, bit tk, bit eq);
        if (req_pending) target = 8'($urandom_range(0, 255));
        req_pending = m_nn;
        start = st; tick = tk;
        sw = eq ? target : target ^ 8'($urandom_range(1, 255));
        @(posedge clk); #1;
        model_step(st, tk, sw == target);
        start = 0; tick = 0;
    endtask

    task automatic do_match(string tag);
        for (int k = 0; k < MH; k++) begin
            drive(0, 0, 1);
            check_model(tag);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1, 0, 0, 1, 0, 30, 1, 0};
        vt[1]  = '{0, 0, 1, 0, 0, 30, 1, 0};
        vt[2]  = '{0, 0, 1, 0, 0, 30, 1, 0};
        vt[3]  = '{0, 0, 1, 0, 0, 30, 1, 0};
        vt[4]  = '{0, 0, 1, 0, 0, 30, 1, 0};
        vt[5]  = '{0, 0, 1, 1, 1, 30, 1, 0};
        vt[6]  = '{0, 0, 0, 0, 1, 30, 1, 0};
        vt[7]  = '{0, 0, 1, 0, 1, 30, 1, 0};
        vt[8]  = '{0, 0, 1, 0, 1, 30, 1, 0};
        vt[9]  = '{0, 0, 1, 0, 1, 30, 1, 0};
        vt[10] = '{0, 0, 0, 0, 1, 30, 1, 0};
        vt[11] = '{0, 0, 1, 0, 1, 30, 1, 0};
        vt[12] = '{0, 1, 0, 0, 1, 29, 1, 0};
        vt[13] = '{1, 0, 0, 0, 1, 29, 1, 0};

        model_reset();
        #12;
        check("rst.new_number", new_number, 0);
        check("rst.score", score, 0);
        check("rst.time", time_remaining, GS);
        check("rst.playing", playing, 0);
        check("rst.game_end", game_end, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            drive(vt[i].st, vt[i].tk, vt[i].eq);
            check($sformatf("vec%0d.new_number", i), new_number, vt[i].nn);
            check($sformatf("vec%0d.score", i), score, vt[i].score);
            check($sformatf("vec%0d.time", i), time_remaining, vt[i].tim);
            check($sformatf("vec%0d.playing", i), playing, vt[i].pl);
            check($sformatf("vec%0d.game_end", i), game_end, vt[i].en);
        end

        // Run the clock out with no matches, then tick again in OVER.
        for (int i = 0; i < 100 && m_phase != P_OVER; i++) begin
            drive(0, 1, 0);
            check_model("timeout");
        end
        check("timeout.game_end", game_end, 1);
        check("timeout.time", time_remaining, 0);
        drive(0, 1, 1);
        check("over_tick.time", time_remaining, 0);
        check("over_tick.score", score, 1);
        check("over_tick.game_end", game_end, 1);

        // Restart from OVER, then saturate the score.
        drive(1, 0, 0);
        check("restart.score", score, 0);
        check("restart.time", time_remaining, GS);
        check("restart.new_number", new_number, 1);
        for (int m = 0; m < 16; m++) begin
            drive(0, 0, 0);
            check_model("sat_settle");
            do_match("sat");
        end
        check("sat.score", score, 15);

        // Last tick lands on the same cycle as a completing match.
        for (int i = 0; i < 100 && m_phase != P_OVER; i++) drive(0, 1, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        do_match("race_pre");
        for (int i = 0; i < 100 && m_time > 1; i++) begin
            drive(0, 1, 0);
            check_model("race_ticks");
        end
        for (int k = 0; k < MH - 1; k++) drive(0, 0, 1);
        drive(0, 1, 1);
        check("race.game_end", game_end, 1);
        check("race.score", score, 1);
        check("race.new_number", new_number, 0);
        check("race.time", time_remaining, 0);

        // Asynchronous reset mid-play with a match in flight.
        drive(1, 0, 0);
        drive(0, 0, 0);
        for (int m = 0; m < 5; m++) begin
            do_match("pre_rst");
            drive(0, 0, 0);
        end
        check("pre_rst.score", score, 5);
        for (int k = 0; k < MH - 1; k++) drive(0, 0, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst.score", score, 0);
        check("async_rst.playing", playing, 0);
        check("async_rst.time", time_remaining, GS);
        check("async_rst.game_end", game_end, 0);
        model_reset();
        @(negedge clk) rst_n = 1;
        drive(1, 0, 1);
        check("post_rst.new_number", new_number, 1);
        check("post_rst.playing", playing, 1);
        drive(0, 0, 1);
        check_model("post_rst_settle");
        do_match("post_rst");
        check("post_rst.score", score, 1);

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 40) == 0, ($urandom % 6) == 0, ($urandom % 8) != 0);
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; there SHALL be no other clock or reset.
REQ-002 Parameter GAME_SECONDS, default 30: round length in seconds, range 1-63.
REQ-003 Parameter MATCH_HOLD, default 16: clk cycles that sw must equal target before a match counts, range 1-255.
REQ-004 clk  in  1  system clock, rising-edge.
REQ-005 rst_n  in  1  asynchronous reset, active low.
REQ-006 start  in  1  debounced start request, one-cycle pulse.
REQ-007 tick  in  1  one-cycle pulse per second, synchronous to clk.
REQ-008 sw  in  8  player switch value.
REQ-009 target  in  8  current random number; it changes only on the cycle after new_number.
REQ-010 new_number  out  1  one-cycle pulse asking the random generator for the next target.
REQ-011 score  out  4  matches this game, saturating at 15.
REQ-012 time_remaining  out  6  seconds left in the game.
REQ-013 playing  out  1  high in PLAY and SETTLE.
REQ-014 game_end  out  1  high in OVER.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, PLAY and OVER; all outputs SHALL be registered.
REQ-016 IDLE: on start, the block SHALL clear score, load time_remaining with GAME_SECONDS, pulse new_number and go to SETTLE.
REQ-017 SETTLE SHALL last exactly 1 cycle, clear the match counter and then go to PLAY.
REQ-018 PLAY: while sw==target, the 8-bit match counter SHALL increment; it SHALL clear on any cycle where sw!=target.
REQ-019 When the counter reaches MATCH_HOLD-1 with sw==target, the block SHALL increment score (saturating at 15), pulse new_number and go to SETTLE; the match therefore registers on the MATCH_HOLD-th consecutive equal cycle.
REQ-020 A tick in PLAY or SETTLE SHALL decrement time_remaining by 1; time_remaining SHALL never go below 0.
REQ-021 When a tick takes time_remaining from 1 to 0, the next state SHALL be OVER with new_number low.
REQ-022 If that tick arrives in the same cycle a match completes, the game SHALL end and score SHALL NOT increment.
REQ-023 OVER SHALL hold score and time_remaining at 0; tick and sw SHALL be ignored.
REQ-024 start in OVER SHALL behave as in IDLE (REQ-016).
REQ-025 start in SETTLE or PLAY SHALL be ignored.
REQ-026 new_number SHALL be asserted only in the cases given in REQ-016, REQ-019 and REQ-024, and never in 2 consecutive cycles.

Reset
REQ-027 While rst_n is low, the block SHALL enter IDLE with score=0, time_remaining=GAME_SECONDS, match counter=0, and new_number, playing and game_end all 0.
REQ-028 Assertion of rst_n SHALL take effect asynchronously mid-game and SHALL discard a pending match.
REQ-029 Release of rst_n SHALL be synchronous to clk.
REQ-030 The first start after reset release SHALL be honoured.

Structure
REQ-031 The state enum, GAME_SECONDS default, MATCH_HOLD default and the score width SHALL live in the shared package game_pkg.
REQ-032 The match counter SHALL be the sub-module match_filter, with inputs clk, rst_n, clear, equal and parameter HOLD, and the single-cycle output hit.
REQ-033 The block SHALL have no combinational path from input to output.

Verification
REQ-034 Reset, then start -> new_number pulses 1 cycle after start; playing=1; time_remaining=30; score=0.
REQ-035 MATCH_HOLD=4; hold sw==target for 4 cycles -> score=1 and new_number pulse; 3 equal cycles then 1 mismatch -> no increment.
REQ-036 30 ticks with no match -> game_end=1, time_remaining=0; a further tick -> no change.
REQ-037 Force 16 matches -> score stays at 15; a tick to 0 in the same cycle as a completing match -> OVER with score unchanged.
REQ-038 rst_n low mid-PLAY with score=5 -> immediate IDLE, score=0; start in OVER -> score=0, time_remaining=30, new_number pulse.
